// File: rtl/pll_lock_ctrl.sv
// Purpose : PLL acquisition/lock sequencer. It gates the error stage, picks the loop-filter gain,
//           holds the DCO and declares or drops frequency lock from per-reference-cycle DCO counts.
// Latency : Moore outputs are decoded from the state register and change one edge after the cause.
//           lock_lost is registered and pulses in the first ACQUIRE cycle after TRACK.
// Backpressure: none; count is sampled on every edge while in ACQUIRE or TRACK.
// Ports   : clk_ref/n_rst      clock and asynchronous active-low reset
//           start/stop         level controls; stop has priority and returns the block to IDLE
//           n/count            target and measured DCO edges per reference cycle
//           err_enable, dco_hold, gain_sel, locked, lock_lost, timeout, state  control/status outputs
module pll_lock_ctrl #(
    parameter int N_SIZE      = 8,
    parameter int TOL         = 2,
    parameter int SETTLE_CYC  = 8,
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_CNT  = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk_ref,
    input  logic              n_rst,
    input  logic              start,
    input  logic              stop,
    input  logic [N_SIZE-1:0] n,
    input  logic [7:0]        count,
    output logic              err_enable,
    output logic              dco_hold,
    output logic [1:0]        gain_sel,
    output logic              locked,
    output logic              lock_lost,
    output logic              timeout,
    output logic [2:0]        state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_ACQUIRE = 3'd2;
    localparam logic [2:0] S_TRACK   = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;

    // Band arithmetic is done one bit wider than the widest operand so n+TOL cannot wrap.
    localparam int W    = ((N_SIZE > 8) ? N_SIZE : 8) + 1;
    localparam int ST_W = $clog2(SETTLE_CYC + 1);
    localparam int LK_W = $clog2(LOCK_CNT + 1);
    localparam int UL_W = $clog2(UNLOCK_CNT + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [W-1:0]    TOL_W   = W'(TOL);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYC - 1);
    localparam logic [ST_W-1:0] ST_MAX  = ST_W'(SETTLE_CYC);
    localparam logic [LK_W-1:0] LK_TGT  = LK_W'(LOCK_CNT);
    localparam logic [UL_W-1:0] UL_TGT  = UL_W'(UNLOCK_CNT);
    localparam logic [TO_W-1:0] TO_TGT  = TO_W'(TIMEOUT_CYC);

    logic [2:0]      state_q, state_d;
    logic [ST_W-1:0] settle_q, settle_d, settle_inc;
    logic [LK_W-1:0] in_q, in_d, in_inc;
    logic [UL_W-1:0] out_q, out_d, out_inc;
    logic [TO_W-1:0] tmo_q, tmo_d, tmo_inc;
    logic            lock_lost_q, lock_lost_d;

    // Lock band: low bound floored at zero, high bound carried in the wide type.
    logic [W-1:0] n_ext, cnt_ext, lo_bnd, hi_bnd;
    logic         in_band;

    assign n_ext   = W'(n);
    assign cnt_ext = W'(count);
    assign lo_bnd  = (n_ext >= TOL_W) ? (n_ext - TOL_W) : '0;
    assign hi_bnd  = n_ext + TOL_W;
    assign in_band = (cnt_ext >= lo_bnd) && (cnt_ext <= hi_bnd);

    // Saturating increments: each counter parks at its terminal value instead of wrapping.
    assign settle_inc = (settle_q == ST_MAX) ? settle_q : settle_q + 1'b1;
    assign in_inc     = (in_q == LK_TGT)     ? in_q     : in_q + 1'b1;
    assign out_inc    = (out_q == UL_TGT)    ? out_q    : out_q + 1'b1;
    assign tmo_inc    = (tmo_q == TO_TGT)    ? tmo_q    : tmo_q + 1'b1;

    // State and counter registers.
    always_ff @(posedge clk_ref or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            settle_q    <= '0;
            in_q        <= '0;
            out_q       <= '0;
            tmo_q       <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            in_q        <= in_d;
            out_q       <= out_d;
            tmo_q       <= tmo_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        in_d     = in_q;
        out_d    = out_q;
        tmo_d    = tmo_q;

        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == ST_LAST) state_d = S_ACQUIRE;
                    else                     settle_d = settle_inc;
                end
                S_ACQUIRE: begin
                    in_d  = in_band ? in_inc : '0;
                    tmo_d = tmo_inc;
                    // Lock is tested first so it wins over a coincident timeout.
                    if (in_band && (in_inc == LK_TGT)) state_d = S_TRACK;
                    else if (tmo_inc == TO_TGT)        state_d = S_FAIL;
                end
                S_TRACK: begin
                    out_d = in_band ? '0 : out_inc;
                    if (!in_band && (out_inc == UL_TGT)) state_d = S_ACQUIRE;
                end
                S_FAIL: begin
                    if (start) state_d = S_SETTLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Every state entry starts all counters from zero.
        if (state_d != state_q) begin
            settle_d = '0;
            in_d     = '0;
            out_d    = '0;
            tmo_d    = '0;
        end
    end

    // Only a genuine TRACK->ACQUIRE drop pulses lock_lost; a stop out of TRACK does not.
    assign lock_lost_d = (state_q == S_TRACK) && (state_d == S_ACQUIRE);

    // Moore output decode.
    always_comb begin
        err_enable = 1'b0;
        dco_hold   = 1'b1;
        gain_sel   = 2'd0;
        locked     = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            S_SETTLE: begin
                dco_hold = 1'b0;
            end
            S_ACQUIRE: begin
                err_enable = 1'b1;
                dco_hold   = 1'b0;
                gain_sel   = 2'd1;
            end
            S_TRACK: begin
                err_enable = 1'b1;
                dco_hold   = 1'b0;
                gain_sel   = 2'd2;
                locked     = 1'b1;
            end
            S_FAIL: begin
                timeout = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign lock_lost = lock_lost_q;
    assign state     = state_q;

endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

Acquisition and lock sequencer for the PLL's frequency/phase error path. It enables the error stage and monitors the per-reference-cycle DCO edge count against the divide ratio `n`. It declares frequency lock after a run of in-band samples and drops lock after a run of out-of-band samples. It also drives the loop-filter gain select, a DCO hold, and a timeout flag. It sits between the top-level control and the error/loop-filter datapath, all on `clk_ref`.

## Interface

Parameters:
- `N_SIZE`, 8: width of `n`.
- `TOL`, 2: lock band half-width in counts, so in-band means `n-TOL <= count <= n+TOL`.
- `SETTLE_CYC`, 8: cycles spent in SETTLE, minimum 1.
- `LOCK_CNT`, 4: consecutive in-band samples needed to lock, minimum 1.
- `UNLOCK_CNT`, 3: consecutive out-of-band samples needed to lose lock, minimum 1.
- `TIMEOUT_CYC`, 64: maximum cycles allowed in ACQUIRE before FAIL.

Ports:
- `clk_ref`, in, 1: reference clock, the only clock.
- `n_rst`, in, 1: asynchronous active-low reset.
- `start`, in, 1: level, sampled each cycle; starts or restarts acquisition.
- `stop`, in, 1: level; returns to IDLE and has priority over `start`.
- `n`, in, `N_SIZE`: target count per reference cycle.
- `count`, in, 8: DCO edges counted in the last reference cycle.
- `err_enable`, out, 1: enable to the error stage.
- `dco_hold`, out, 1: freezes the DCO control word.
- `gain_sel`, out, 2: loop-filter gain; 0 = off, 1 = coarse, 2 = fine.
- `locked`, out, 1: frequency lock achieved.
- `lock_lost`, out, 1: one-cycle pulse on the TRACK→ACQUIRE transition.
- `timeout`, out, 1: acquisition failed.
- `state`, out, 3: current state code, for debug.

## Operation

States and codes: IDLE=0, SETTLE=1, ACQUIRE=2, TRACK=3, FAIL=4. Codes 5–7 are illegal and go to IDLE.

Outputs per state (Moore, decoded from the state register):
- IDLE: `err_enable`=0, `dco_hold`=1, `gain_sel`=0, `locked`=0, `timeout`=0.
- SETTLE: `err_enable`=0, `dco_hold`=0, `gain_sel`=0.
- ACQUIRE: `err_enable`=1, `dco_hold`=0, `gain_sel`=1.
- TRACK: `err_enable`=1, `dco_hold`=0, `gain_sel`=2, `locked`=1.
- FAIL: `err_enable`=0, `dco_hold`=1, `gain_sel`=0, `timeout`=1.
- `lock_lost` is registered and is 1 only in the first ACQUIRE cycle that follows TRACK.

Transitions, evaluated in priority order:
- `stop`=1 in any state → IDLE.
- IDLE, `start`=1 → SETTLE.
- SETTLE: the timer counts `SETTLE_CYC` cycles, then → ACQUIRE.
- ACQUIRE:
  - An in-band sample increments `in_cnt`; an out-of-band sample clears it.
  - When `in_cnt` reaches `LOCK_CNT` on this sample → TRACK.
  - Otherwise, if the cycle counter reaches `TIMEOUT_CYC` → FAIL.
  - Lock takes priority over timeout when both occur in the same cycle.
- TRACK:
  - An out-of-band sample increments `out_cnt`; an in-band sample clears it.
  - When `out_cnt` reaches `UNLOCK_CNT` → ACQUIRE, with `lock_lost` pulsed.
- FAIL, `start`=1 → SETTLE (retry). Otherwise FAIL holds.
- `start` in SETTLE, ACQUIRE or TRACK is ignored.

Counter behaviour:
- All counters (settle timer, `in_cnt`, `out_cnt`, timeout counter) clear on every state entry.
- The counters saturate and never wrap.

Arithmetic:
- Zero-extend `count` and `n` to W = max(`N_SIZE`, 8) + 1 bits.
- Low bound = `n` − `TOL`, floored at 0 (no underflow).
- High bound = `n` + `TOL` in W bits (no overflow).
- Example: `n`=1, `TOL`=2 gives a band of 0..3. `n`=255 gives a band of 253..257, so `count`=255 is in band.

## Timing

- Reset values: `state`=IDLE, `err_enable`=0, `dco_hold`=1, `gain_sel`=0, `locked`=0, `lock_lost`=0, `timeout`=0, all counters 0.
- Reset asserted mid-operation forces these values immediately (asynchronous reset).
- `start` high at edge k puts the block in SETTLE after edge k. It reaches ACQUIRE after edge k+`SETTLE_CYC`.
- `count` is sampled on each edge while in ACQUIRE or TRACK. The first ACQUIRE sample is at the first edge after entry.
- `locked` rises after the edge that sees the `LOCK_CNT`-th consecutive in-band sample.
- The minimum time from `start` to `locked` is 1 + `SETTLE_CYC` + `LOCK_CNT` edges.
- If `stop` and `start` are high together, the block goes to IDLE.
- `stop` held high keeps the block in IDLE.

## Test plan

Bench parameters for all scenarios: `n`=50, `TOL`=2, `SETTLE_CYC`=8, `LOCK_CNT`=4, `UNLOCK_CNT`=3, `TIMEOUT_CYC`=64.

- Reset, then `start` for one cycle with `count`=50 held → `state` goes 0→1 for 8 cycles→2; `gain_sel`=1; after 4 samples `state`=3, `locked`=1, `gain_sel`=2.
- In ACQUIRE, `count` sequence 48, 52, 53, 50, 51, 49, 50 → the 53 resets the run; TRACK entered after the final 50.
- In TRACK, `count`=60, 60, 50, 60, 60, 60 → stays locked through the first pair; after the third consecutive 60, `lock_lost`=1 for exactly one cycle, `locked`=0, `state`=2.
- In ACQUIRE with `count`=30 constant → FAIL after 64 cycles with `timeout`=1 and `dco_hold`=1; `start` → SETTLE with `timeout`=0.
- `stop` asserted together with `start` in TRACK → IDLE next cycle with all outputs at reset values; also check `n`=1 with `count`=0 in band and `n`=255 with `count`=255 in band.
- Assert `n_rst` low mid-SETTLE and mid-TRACK → outputs at reset values immediately, without waiting for a clock edge.
